// File: rtl/legv8_mem_pkg.sv
// Shared types and constants for the LEGv8 unified-memory arbiter.
package legv8_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int WORD_ALIGN_BITS = 3;

endpackage

// File: rtl/legv8_mem_prio.sv
// Combinational fetch/data priority: data wins unless the streak limit is hit while fetch waits.
module legv8_mem_prio (
  input  logic if_req,
  input  logic d_req,
  input  logic streak_full,
  output logic if_gnt,
  output logic d_gnt
);

  assign d_gnt  = d_req & ~(streak_full & if_req);
  assign if_gnt = if_req & ~d_gnt;

endmodule

// File: rtl/legv8_mem_arbiter.sv
// Shares one fixed-latency 64-bit memory between instruction fetch and LDUR/STUR,
// sequencing each access as grant -> MEM_LAT access cycles -> one response cycle.
module legv8_mem_arbiter
  import legv8_mem_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int MAX_STREAK = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [63:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        stall,
  output logic        busy
);

  localparam int SW = $clog2(MAX_STREAK + 1);

  state_t        state, state_nx;
  owner_t        owner;
  logic [3:0]    cnt;
  logic          lat_we;
  logic [63:0]   lat_addr;
  logic [63:0]   lat_wdata;
  logic [SW-1:0] streak;

  logic window, arb_if, arb_d, streak_full, grant, last_access;

  assign streak_full = (streak == SW'(MAX_STREAK));

  legv8_mem_prio u_prio (
    .if_req      (if_req),
    .d_req       (d_req),
    .streak_full (streak_full),
    .if_gnt      (arb_if),
    .d_gnt       (arb_d)
  );

  // Grants are only offered while the memory is not being driven.
  assign window      = (state == IDLE) || (state == RESP);
  assign if_gnt      = window & arb_if;
  assign d_gnt       = window & arb_d;
  assign grant       = if_gnt | d_gnt;
  assign stall       = if_req & ~if_gnt;
  assign last_access = (state == ACCESS) && (cnt == 4'd0);

  assign mem_addr  = {lat_addr[63:WORD_ALIGN_BITS], {WORD_ALIGN_BITS{1'b0}}};
  assign mem_wdata = lat_wdata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    if_valid = 1'b0;
    d_valid  = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE: begin
        if (grant) state_nx = ACCESS;
      end
      ACCESS: begin
        mem_en = 1'b1;
        mem_we = lat_we;
        if (cnt == 4'd0) state_nx = RESP;
      end
      RESP: begin
        if_valid = (owner == OWN_IF);
        d_valid  = (owner == OWN_D);
        state_nx = grant ? ACCESS : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request latching, latency counter, starvation streak and read-data capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner     <= OWN_IF;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 64'd0;
      lat_wdata <= 64'd0;
      streak    <= '0;
      if_rdata  <= 32'd0;
      d_rdata   <= 64'd0;
    end else begin
      if (grant) cnt <= 4'(MEM_LAT - 1);
      else if (state == ACCESS && cnt != 4'd0) cnt <= cnt - 4'd1;

      if (d_gnt) begin
        owner     <= OWN_D;
        lat_we    <= d_we;
        lat_addr  <= d_addr;
        lat_wdata <= d_wdata;
        if (!if_req)          streak <= '0;
        else if (!streak_full) streak <= streak + 1'b1;
      end else if (if_gnt) begin
        owner     <= OWN_IF;
        lat_we    <= 1'b0;
        lat_addr  <= if_addr;
        streak    <= '0;
      end

      if (last_access) begin
        if (owner == OWN_IF)
          if_rdata <= lat_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
        else if (!lat_we)
          d_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: doc/legv8_mem_arbiter.md
Name: legv8_mem_arbiter

Overview:
- Shares one single-ported, fixed-latency 64-bit memory between the instruction-fetch path and the data path (LDUR/STUR).
- Sequences every access: arbitrate, hold the memory for MEM_LAT cycles, then return a completion pulse.
- Sits between the PC/fetch logic, the control-unit-driven datapath and the unified memory. Exports a stall that the control unit uses to freeze the PC and ControlWord.

Parameters:
- MEM_LAT, 2: cycles the memory needs from the mem_en rising edge to valid mem_rdata, range 1-15.
- MAX_STREAK, 4: consecutive data grants allowed while a fetch is waiting; the next grant then goes to fetch.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, held until if_gnt.
- if_addr  in  64  fetch byte address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_valid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  32  instruction word.
- d_req  in  1  data request, held until d_gnt.
- d_we  in  1  1 = STUR write, 0 = LDUR read.
- d_addr  in  64  data byte address.
- d_wdata  in  64  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_valid  out  1  one-cycle completion pulse, for reads and writes.
- d_rdata  out  64  load data.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  64  memory word address.
- mem_wdata  out  64  memory write data.
- mem_rdata  in  64  memory read data.
- stall  out  1  fetch pending and not granted this cycle.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE; streak = 0.
  - All outputs 0, including if_rdata and d_rdata.
  - Any in-flight access is abandoned; no valid pulse is ever issued for it.
- States: IDLE, ACCESS, RESP.
- Grant window:
  - Arbitration happens in IDLE and RESP.
  - if_gnt and d_gnt are combinational and mutually exclusive.
  - The granted request's addr, we and wdata are latched on that clock edge; the requester may drop req the following cycle.
- Priority:
  - Data wins, except when streak == MAX_STREAK and if_req=1; then fetch wins.
- streak:
  - Increments on a data grant while if_req=1, saturating at MAX_STREAK.
  - Clears on a fetch grant, or on a data grant while if_req=0.
- Transitions:
  - Grant in IDLE or RESP -> ACCESS, with counter = MAX_LAT-1 (i.e. MEM_LAT-1).
  - ACCESS with counter != 0 -> ACCESS, counter decrements.
  - ACCESS with counter == 0 -> RESP.
  - RESP with no request -> IDLE.
- ACCESS outputs:
  - mem_en = 1.
  - mem_we = latched we, fetch always 0.
  - mem_addr = {latched_addr[63:3], 3'b000}; low bits are ignored and there is no misalignment error.
  - mem_wdata = latched wdata.
- Outside ACCESS: mem_en = 0, mem_we = 0, mem_addr and mem_wdata hold their last values.
- Read data capture:
  - mem_rdata is captured on the last ACCESS edge.
  - Fetch: if_rdata = latched_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0].
  - Data read: d_rdata = mem_rdata.
  - if_rdata and d_rdata hold until the next completion of the same kind.
  - A data write leaves d_rdata unchanged.
- Completion: if_valid or d_valid is high for exactly the RESP cycle, for the owner only.
- Latency and throughput:
  - A grant at cycle 0 gives valid at cycle MEM_LAT+1.
  - A back-to-back grant in RESP gives throughput of one access per MEM_LAT+1 cycles.
- Simultaneous events:
  - Both requests in the same cycle: priority rule applies; the loser stays pending.
  - A new request arriving during ACCESS waits; no grant is given in ACCESS.
- stall = if_req & ~if_gnt, in every state.
- Reset asserted mid-ACCESS: mem_en drops asynchronously; a write may or may not have completed and the block makes no guarantee.

Decomposition:
- Shared package legv8_mem_pkg:
  - State encoding IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - Owner encoding OWN_IF=1'b0, OWN_D=1'b1.
  - Constant WORD_ALIGN_BITS=3.
- One sub-module, legv8_mem_prio:
  - Combinational arbitration of (if_req, d_req, streak==MAX_STREAK) into (if_gnt, d_gnt).
  - Separated so it can be reused by a later cache-refill arbiter.
- Counter and FSM stay in the top module.

Test Plan (MEM_LAT=2, MAX_STREAK=4):
- Reset, then a lone fetch:
  - Stimulus: if_addr=0x0000000000000004; mem_rdata returns 0x8B1F0002_D2800000 on the last ACCESS edge.
  - Response: if_gnt at cycle 0; mem_en high at cycles 1-2 with mem_addr=0x0; if_valid at cycle 3; if_rdata=0x8B1F0002.
- STUR:
  - Stimulus: d_we=1, d_addr=0x10, d_wdata=0xDEADBEEFCAFEF00D.
  - Response: mem_we=1 for 2 cycles with mem_addr=0x10; d_valid at cycle 3; d_rdata unchanged (0).
- Simultaneous if_req and d_req (LDUR, addr 0x18):
  - Response: d_gnt first; stall=1 through RESP; fetch granted in the RESP cycle; if_valid 3 cycles after d_valid.
- Starvation guard:
  - Stimulus: d_req held continuously with if_req=1.
  - Response: exactly 4 d_gnt, then if_gnt on the 5th grant; streak returns to 0.
- Reset mid-ACCESS:
  - Stimulus: reset=0 asserted at cycle 1 of a read.
  - Response: mem_en=0 immediately; no d_valid ever; after release, busy=0 and the next fetch completes normally.
- Back-to-back fetches with if_req held:
  - Stimulus: if_addr 0x0, then 0x4.
  - Response: if_valid pulses at cycles 3 and 6; grants at cycles 0 and 3; mem_en low only in the RESP cycles.
